// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FWFT-buffered UART transmitter with per-frame latched framing config
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            clks_per_bit,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        two_stop,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic [DIV_W-1:0] div_q, p_q, p_in;
  logic [BW-1:0] bit_q;
  logic pe_q, two_q, par_q, txd_q, busy_q, done_q;
  logic push, pop, tick, last_stop;
  always_comb begin
    p_in      = clks_per_bit < DIV_W'(2) ? DIV_W'(2) : clks_per_bit;
    tick      = div_q == '0;
    last_stop = !two_q || bit_q[0];
    push      = in_valid && in_ready;
    pop       = cnt_q != '0 && (state_q == IDLE || (state_q == STOP && tick && last_stop));
  end
  assign in_ready   = cnt_q != FULL;
  assign fifo_level = cnt_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= in_data;
  always_ff @(posedge clk)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      p_q     <= DIV_W'(2);
      pe_q    <= 1'b0;
      two_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      done_q <= state_q == STOP && div_q == DIV_W'(1) && last_stop;
      if (pop) begin
        sh_q    <= mem[rd_q];
        p_q     <= p_in;
        div_q   <= p_in - DIV_W'(1);
        pe_q    <= parity_en;
        two_q   <= two_stop;
        par_q   <= (^mem[rd_q]) ^ parity_odd;
        txd_q   <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= START;
      end else if (state_q != IDLE) begin
        if (!tick) div_q <= div_q - DIV_W'(1);
        else begin
          div_q <= p_q - DIV_W'(1);
          case (state_q)
            START: begin
              txd_q   <= sh_q[0];
              sh_q    <= sh_q >> 1;
              bit_q   <= '0;
              state_q <= DATA;
            end
            DATA:
              if (bit_q == BW'(DATA_W-1)) begin
                bit_q   <= '0;
                txd_q   <= pe_q ? par_q : 1'b1;
                state_q <= pe_q ? PARITY : STOP;
              end else begin
                bit_q <= bit_q + BW'(1);
                txd_q <= sh_q[0];
                sh_q  <= sh_q >> 1;
              end
            PARITY: begin
              txd_q   <= 1'b1;
              bit_q   <= '0;
              state_q <= STOP;
            end
            STOP:
              if (!last_stop) bit_q <= bit_q + BW'(1);
              else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
endmodule
